// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: words queue in a circular FIFO and are sent LSB-first
// with configurable data width, parity and stop bits at CLK_FREQ/BAUD clocks per bit.
module uart_tx_fifo #(
    parameter int CLK_FREQ  = 100_000_000,
    parameter int BAUD      = 9600,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1,
    parameter int DEPTH     = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [DATA_BITS-1:0]     wr_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     busy,
    output logic                     tx
);
    localparam int DIV = CLK_FREQ / BAUD;
    localparam int AW  = $clog2(DEPTH);
    localparam int CW  = $clog2(DIV);

    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

    logic [DATA_BITS-1:0] mem [DEPTH];
    logic [AW:0]          wr_ptr;
    logic [AW:0]          rd_ptr;
    logic                 push;
    logic                 pop;

    state_t               state;
    state_t               state_nxt;
    logic [CW-1:0]        baud_cnt;
    logic [CW-1:0]        baud_cnt_nxt;
    logic [2:0]           bit_cnt;
    logic [2:0]           bit_cnt_nxt;
    logic [DATA_BITS-1:0] shreg;
    logic [DATA_BITS-1:0] shreg_nxt;
    logic                 par_bit;
    logic                 par_bit_nxt;
    logic                 tx_nxt;
    logic                 bit_end;
    logic                 load;

    function automatic logic parity_of(input logic [DATA_BITS-1:0] w);
        return (^w) ^ (PARITY == 1);
    endfunction

    // Occupancy decoded from the extra pointer bit, so full is known before any pop.
    assign level = wr_ptr - rd_ptr;
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign push  = wr_en && !full;
    assign busy  = (state != IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

    assign bit_end = (baud_cnt == CW'(DIV - 1));

    always_comb begin
        state_nxt    = state;
        baud_cnt_nxt = bit_end ? '0 : baud_cnt + CW'(1);
        bit_cnt_nxt  = bit_cnt;
        shreg_nxt    = shreg;
        par_bit_nxt  = par_bit;
        tx_nxt       = tx;
        load         = 1'b0;
        pop          = 1'b0;
        case (state)
            IDLE: begin
                baud_cnt_nxt = '0;
                tx_nxt       = 1'b1;
                load         = !empty;
            end
            START: if (bit_end) begin
                tx_nxt      = shreg[0];
                bit_cnt_nxt = '0;
                state_nxt   = DATA;
            end
            DATA: if (bit_end) begin
                shreg_nxt = shreg >> 1;
                if (bit_cnt == 3'(DATA_BITS - 1)) begin
                    bit_cnt_nxt = '0;
                    if (PARITY != 0) begin
                        tx_nxt    = par_bit;
                        state_nxt = PAR;
                    end else begin
                        tx_nxt    = 1'b1;
                        state_nxt = STOP;
                    end
                end else begin
                    bit_cnt_nxt = bit_cnt + 3'd1;
                    tx_nxt      = shreg[1];
                end
            end
            PAR: if (bit_end) begin
                tx_nxt    = 1'b1;
                state_nxt = STOP;
            end
            STOP: if (bit_end) begin
                if (bit_cnt == 3'(STOP_BITS - 1)) begin
                    if (!empty) load = 1'b1;
                    else        state_nxt = IDLE;
                end else begin
                    bit_cnt_nxt = bit_cnt + 3'd1;
                end
            end
            default: state_nxt = IDLE;
        endcase
        // A pop always starts a start bit on the same edge, from IDLE or back-to-back.
        if (load) begin
            pop          = 1'b1;
            shreg_nxt    = mem[rd_ptr[AW-1:0]];
            par_bit_nxt  = parity_of(mem[rd_ptr[AW-1:0]]);
            tx_nxt       = 1'b0;
            baud_cnt_nxt = '0;
            state_nxt    = START;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            tx       <= 1'b1;
        end else begin
            state    <= state_nxt;
            baud_cnt <= baud_cnt_nxt;
            bit_cnt  <= bit_cnt_nxt;
            tx       <= tx_nxt;
        end
    end

    always_ff @(posedge clk) begin
        shreg   <= shreg_nxt;
        par_bit <= par_bit_nxt;
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: five configurations, table vectors, hand-written corner
// sequences and a randomized run against a frame-level reference model.
module tb_uart_tx_fifo;
    localparam int E_DIV   = 8;
    localparam int E_FRAME = 10 * E_DIV;
    localparam int E_DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] wr_en;
    logic [7:0] wr_data;
    logic [4:0] full_v, empty_v, busy_v, tx_v;
    logic [4:0] lvl_a, lvl_b, lvl_c, lvl_d;
    logic [2:0] lvl_e;
    int n_cmp = 0;
    int n_bad = 0;
    int lvl_over = 0;

    typedef struct {
        int         inst;
        logic [7:0] d;
        int         div;
        int         nb;
        logic [15:0] exp;
    } vec_t;
    vec_t vecs [6];

    always #5 clk = ~clk;

    // a: 8N1 DIV16 | b: 7E2 DIV4 | c: 7O2 DIV4 | d: 8N1 DIV4 | e: 8N1 DIV8 DEPTH4
    uart_tx_fifo #(.CLK_FREQ(16), .BAUD(1), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .DEPTH(16)) u_a (
        .clk(clk), .rst(rst), .wr_en(wr_en[0]), .wr_data(wr_data), .full(full_v[0]),
        .empty(empty_v[0]), .level(lvl_a), .busy(busy_v[0]), .tx(tx_v[0]));
    uart_tx_fifo #(.CLK_FREQ(4), .BAUD(1), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2), .DEPTH(16)) u_b (
        .clk(clk), .rst(rst), .wr_en(wr_en[1]), .wr_data(wr_data[6:0]), .full(full_v[1]),
        .empty(empty_v[1]), .level(lvl_b), .busy(busy_v[1]), .tx(tx_v[1]));
    uart_tx_fifo #(.CLK_FREQ(4), .BAUD(1), .DATA_BITS(7), .PARITY(1), .STOP_BITS(2), .DEPTH(16)) u_c (
        .clk(clk), .rst(rst), .wr_en(wr_en[2]), .wr_data(wr_data[6:0]), .full(full_v[2]),
        .empty(empty_v[2]), .level(lvl_c), .busy(busy_v[2]), .tx(tx_v[2]));
    uart_tx_fifo #(.CLK_FREQ(4), .BAUD(1), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .DEPTH(16)) u_d (
        .clk(clk), .rst(rst), .wr_en(wr_en[3]), .wr_data(wr_data), .full(full_v[3]),
        .empty(empty_v[3]), .level(lvl_d), .busy(busy_v[3]), .tx(tx_v[3]));
    uart_tx_fifo #(.CLK_FREQ(E_DIV), .BAUD(1), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .DEPTH(E_DEPTH)) u_e (
        .clk(clk), .rst(rst), .wr_en(wr_en[4]), .wr_data(wr_data), .full(full_v[4]),
        .empty(empty_v[4]), .level(lvl_e), .busy(busy_v[4]), .tx(tx_v[4]));

    function automatic logic [4:0] lvl(input int k);
        case (k)
            0:       return lvl_a;
            1:       return lvl_b;
            2:       return lvl_c;
            3:       return lvl_d;
            default: return {2'b00, lvl_e};
        endcase
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            if (n_bad <= 25)
                $display("FAIL %s: actual %0h required %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model for instance e: a queue of words plus the clocks left in the current frame.
    logic [7:0] mq [$];
    int         rem = 0;
    logic [7:0] cur = '0;
    bit         mdl_on = 1'b0;

    function automatic logic line_bit(input logic [7:0] w, input int idx);
        if (idx == 0) return 1'b0;
        if (idx <= 8) return w[idx-1];
        return 1'b1;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            mq.delete();
            rem = 0;
        end else begin : mdl_step
            int pre;
            bit do_pop, do_push;
            pre     = mq.size();
            do_pop  = (rem <= 1) && (pre > 0);
            do_push = (wr_en[4] === 1'b1) && (pre < E_DEPTH);
            if (do_pop) begin
                cur = mq.pop_front();
                rem = E_FRAME;
            end else if (rem > 0) begin
                rem--;
            end
            if (do_push) mq.push_back(wr_data);
        end
    end

    always @(negedge clk) begin
        if (mdl_on && rst === 1'b1) begin : mdl_chk
            int   sz;
            logic etx;
            sz  = mq.size();
            etx = 1'b1;
            if (rem > 0) etx = line_bit(cur, (E_FRAME - rem) / E_DIV);
            check("model_e {tx,busy,full,empty,level}",
                  32'({tx_v[4], busy_v[4], full_v[4], empty_v[4], lvl_e}),
                  32'({etx, rem > 0, sz == E_DEPTH, sz == 0, 3'(sz)}));
            if (lvl_e > 3'(E_DEPTH)) lvl_over++;
        end
    end

    // Line receiver on instance e, sampling mid-bit.
    int         mon_t = -1;
    logic [7:0] mon_sh = '0;
    logic [7:0] rxq [$];

    always @(negedge clk or negedge rst) begin
        if (!rst) begin
            mon_t = -1;
        end else if (mon_t < 0) begin
            if (tx_v[4] === 1'b0) mon_t = 0;
        end else begin
            mon_t++;
            if (mon_t % E_DIV == E_DIV / 2 && mon_t / E_DIV >= 1 && mon_t / E_DIV <= 8)
                mon_sh[mon_t / E_DIV - 1] = tx_v[4];
            if (mon_t == 9 * E_DIV + E_DIV / 2) begin
                rxq.push_back(mon_sh);
                mon_t = -1;
            end
        end
    end

    task automatic run_vector(input int i);
        vec_t v;
        int bad, bcnt;
        v = vecs[i];
        bad = 0;
        bcnt = 0;
        @(negedge clk); wr_data = v.d; wr_en[v.inst] = 1'b1;
        @(negedge clk); wr_en[v.inst] = 1'b0;
        check($sformatf("vec%0d_tx_before_pop", i), 32'(tx_v[v.inst]), 1);
        check($sformatf("vec%0d_level_after_write", i), 32'(lvl(v.inst)), 1);
        check($sformatf("vec%0d_busy_before_pop", i), 32'(busy_v[v.inst]), 0);
        for (int b = 0; b < v.nb; b++) begin
            for (int c = 0; c < v.div; c++) begin
                @(negedge clk);
                if (tx_v[v.inst] !== v.exp[b]) bad++;
                if (busy_v[v.inst] === 1'b1) bcnt++;
            end
        end
        check($sformatf("vec%0d_line_bits_wrong", i), bad, 0);
        check($sformatf("vec%0d_busy_clocks", i), bcnt, v.nb * v.div);
        @(negedge clk);
        check($sformatf("vec%0d_idle_after {busy,tx}", i), 32'({busy_v[v.inst], tx_v[v.inst]}), 32'b01);
    endtask

    task automatic wait_idle(input int k, input int bound, input string nm);
        int t;
        t = 0;
        while (t < bound && !(busy_v[k] === 1'b0 && empty_v[k] === 1'b1)) begin
            @(negedge clk);
            t++;
        end
        check(nm, 32'(t >= bound), 0);
    endtask

    int b_bad = 0;
    int b_bcnt = 0;
    logic [7:0] bwords [3];

    task automatic burst_sample(input int idx);
        logic [9:0] fr;
        fr = {1'b1, bwords[idx / 40], 1'b0};
        if (tx_v[3] !== fr[(idx % 40) / 4]) b_bad++;
        if (busy_v[3] === 1'b1) b_bcnt++;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] sent [$];
        logic [4:0] blv [3];
        int bad, gap, guard;
        logic [7:0] d;

        vecs[0] = '{0, 8'hA5, 16, 10, 16'h034A};
        vecs[1] = '{1, 8'h55, 4, 11, 16'h06AA};
        vecs[2] = '{2, 8'h55, 4, 11, 16'h07AA};
        vecs[3] = '{1, 8'h03, 4, 11, 16'h0606};
        vecs[4] = '{2, 8'h01, 4, 11, 16'h0602};
        vecs[5] = '{3, 8'h3C, 4, 10, 16'h0278};

        rst = 1'b0;
        wr_en = '0;
        wr_data = '0;
        #12;
        for (int k = 0; k < 5; k++)
            check($sformatf("reset_state%0d {tx,busy,full,empty,level}", k),
                  32'({tx_v[k], busy_v[k], full_v[k], empty_v[k], lvl(k)}), 32'({4'b1001, 5'd0}));
        @(negedge clk); wr_en[0] = 1'b1; wr_data = 8'h77;
        @(negedge clk); wr_en[0] = 1'b0;
        check("write_ignored_in_reset_level", 32'(lvl(0)), 0);
        @(negedge clk); rst = 1'b1; mdl_on = 1'b1;
        repeat (3) @(negedge clk);
        check("after_release_busy", 32'(busy_v[0]), 0);

        for (int i = 0; i < 6; i++) run_vector(i);

        // Burst of three words on the DIV=4 8N1 instance.
        bwords[0] = 8'h01; bwords[1] = 8'h02; bwords[2] = 8'h03;
        blv[0] = 5'd1; blv[1] = 5'd1; blv[2] = 5'd2;
        @(negedge clk); wr_en[3] = 1'b1; wr_data = bwords[0];
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("burst_level_step%0d", i), 32'(lvl(3)), 32'(blv[i]));
            if (i < 2) wr_data = bwords[i+1];
            else       wr_en[3] = 1'b0;
            if (i >= 1) burst_sample(i - 1);
        end
        for (int idx = 2; idx < 120; idx++) begin
            @(negedge clk);
            burst_sample(idx);
            if (idx == 39) check("burst_level_before_frame2", 32'(lvl(3)), 2);
            if (idx == 40) check("burst_level_at_frame2", 32'(lvl(3)), 1);
            if (idx == 80) check("burst_level_at_frame3", 32'(lvl(3)), 0);
        end
        check("burst_line_bits_wrong", b_bad, 0);
        check("burst_busy_clocks", b_bcnt, 120);
        @(negedge clk);
        check("burst_idle_after", 32'(busy_v[3]), 0);

        // Overflow on the DEPTH=4 instance: 0x15 must be dropped.
        rxq.delete();
        @(negedge clk); wr_en[4] = 1'b1; wr_data = 8'h10;
        for (int i = 1; i < 6; i++) begin
            @(negedge clk); wr_data = 8'h10 + 8'(i);
        end
        @(negedge clk); wr_en[4] = 1'b0;
        check("ovf_full", 32'(full_v[4]), 1);
        check("ovf_level", 32'(lvl_e), 4);
        repeat (75) @(negedge clk);
        check("ovf_full_before_frame2", 32'(full_v[4]), 1);
        @(negedge clk);
        check("ovf_full_at_frame2", 32'(full_v[4]), 0);
        check("ovf_level_at_frame2", 32'(lvl_e), 3);
        wait_idle(4, 1000, "ovf_drain_timeout");
        check("ovf_rx_count", rxq.size(), 5);
        bad = 0;
        for (int i = 0; i < 5 && i < rxq.size(); i++)
            if (rxq[i] !== 8'h10 + 8'(i)) bad++;
        check("ovf_rx_words_wrong", bad, 0);

        // Asynchronous reset in the middle of a start bit with a word still queued.
        @(negedge clk); wr_en[0] = 1'b1; wr_data = 8'hFF;
        @(negedge clk); wr_data = 8'h00;
        @(negedge clk); wr_en[0] = 1'b0;
        repeat (4) @(negedge clk);
        check("rst_pre_tx_in_start_bit", 32'(tx_v[0]), 0);
        check("rst_pre_level", 32'(lvl(0)), 1);
        @(posedge clk); #3 rst = 1'b0; #1;
        check("rst_async {tx,busy,empty,level}",
              32'({tx_v[0], busy_v[0], empty_v[0], lvl(0)}), 32'({3'b101, 5'd0}));
        @(negedge clk); rst = 1'b1;
        bad = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (tx_v[0] !== 1'b1 || busy_v[0] !== 1'b0 || empty_v[0] !== 1'b1) bad++;
        end
        check("rst_no_resume_bad_cycles", bad, 0);

        // Randomized push/drain across several pointer wraps.
        rxq.delete();
        for (int n = 0; n < 40; n++) begin
            gap = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 200)) : 0;
            repeat (gap) @(negedge clk);
            guard = 0;
            while (mq.size() >= E_DEPTH && guard < 1000) begin
                @(negedge clk);
                guard++;
            end
            if (guard >= 1000) check("rand_space_timeout", 1, 0);
            d = 8'($urandom_range(0, 255));
            wr_data = d;
            wr_en[4] = 1'b1;
            sent.push_back(d);
            @(negedge clk); wr_en[4] = 1'b0;
        end
        wait_idle(4, 2000, "rand_drain_timeout");
        check("rand_rx_count", rxq.size(), sent.size());
        bad = 0;
        for (int n = 0; n < sent.size() && n < rxq.size(); n++)
            if (rxq[n] !== sent[n]) bad++;
        check("rand_rx_words_wrong", bad, 0);
        check("level_above_depth_cycles", lvl_over, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
